// File: rtl/ripple_carry_adder_32b.sv
// Registered WIDTH-bit adder built from an explicit ripple chain of full-adder cells.
// One-cycle latency; Sum/Cout/Overflow load only on valid input and hold otherwise.
module ripple_carry_adder_32b #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    assign carry[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum_comb[i]  = A[i] ^ B[i] ^ carry[i];
        assign carry[i+1]   = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end

    logic [WIDTH-1:0] sum_q,  sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q,  ovf_d;
    logic             vld_q,  vld_d;

    // Hold path is selected whenever in_valid is low, so idle-cycle operands never reach the register.
    always_comb begin
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        vld_d  = in_valid;
        if (in_valid) begin
            sum_d  = sum_comb;
            cout_d = carry[WIDTH];
            ovf_d  = carry[WIDTH-1] ^ carry[WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            vld_q  <= vld_d;
        end
    end

    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Overflow  = ovf_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_ripple_carry_adder_32b.sv
// Scoreboard bench for ripple_carry_adder_32b: directed vectors push expected results,
// a monitor pops and compares whenever out_valid is seen.
module tb_ripple_carry_adder_32b;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  A, B;
    logic          Cin;
    logic [W-1:0]  Sum;
    logic          Cout, Overflow, out_valid;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cyc;
        string        name;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    ripple_carry_adder_32b #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Sum       (Sum),
        .Cout      (Cout),
        .Overflow  (Overflow),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_sum"},   64'(Sum),       64'h0);
        chk({name, "_cout"},  64'(Cout),      64'h0);
        chk({name, "_ovf"},   64'(Overflow),  64'h0);
        chk({name, "_valid"}, 64'(out_valid), 64'h0);
    endtask

    // Drive one valid operand set just after a falling edge; result expected one edge later.
    task automatic issue(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic [W-1:0] es, input logic ec, input logic eo);
        exp_t e;
        @(negedge clk);
        #1;
        A = a; B = b; Cin = cin; in_valid = 1'b1;
        e.sum = es; e.cout = ec; e.ovf = eo; e.cyc = cyc + 1; e.name = name;
        q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D; Cin = 1'b1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain_left"}, 64'(q.size()), 64'h0);
    endtask

    // Monitor: every presented result must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: got out_valid=1 sum=0x%0h expected no output", Sum);
                end else begin
                    e = q.pop_front();
                    chk({e.name, "_sum"},     64'(Sum),      64'(e.sum));
                    chk({e.name, "_cout"},    64'(Cout),     64'(e.cout));
                    chk({e.name, "_ovf"},     64'(Overflow), 64'(e.ovf));
                    chk({e.name, "_latency"}, 64'(cyc),      64'(e.cyc));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0;
        #1;
        chk_zero("reset");
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;

        issue("add_1_2", 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk("hold_valid", 64'(out_valid), 64'h0);
        chk("hold_sum",   64'(Sum),       64'h3);
        drain("first");

        issue("wrap",      32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        issue("alt",       32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue("alt_cin",   32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        issue("mixed",     32'h1234_5678, 32'h8765_4321, 1'b1, 32'h9999_999A, 1'b0, 1'b0);
        issue("pos_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        issue("neg_ovf",   32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        issue("ones_cin",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        idle();
        drain("vectors");

        issue("stream0", 32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0, 1'b0);
        issue("stream1", 32'hFFFF_0000, 32'h0001_FFFF, 1'b0, 32'h0000_FFFF, 1'b1, 1'b0);
        issue("stream2", 32'h4000_0000, 32'h4000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        issue("inflight", 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        q.delete();
        in_valid = 1'b1; A = 32'h1111_1111; B = 32'h2222_2222;
        @(negedge clk);
        chk_zero("reset_hold");
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        issue("after_reset", 32'h0000_0005, 32'h0000_0007, 1'b0, 32'h0000_000C, 1'b0, 1'b0);
        idle();
        drain("final");
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
